// File: rtl/ysyx_23060061_pkg.sv
// Shared definitions for the AXI arbiter slice: arbiter state encoding and
// AXI response/burst constants.
package ysyx_23060061_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    WR1  = 2'd3
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam logic [1:0] BURST_INCR  = 2'd1;

endpackage

// File: rtl/ysyx_23060061_rr_arb.sv
// Two-request round-robin arbiter; the pointer flips whenever the owner
// commits to a read grant.
module ysyx_23060061_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic grant_accept,
  output logic gnt0,
  output logic gnt1
);

  logic rr;

  // rr=0 favours req0 when both are pending; a lone requester always wins.
  assign gnt0 = req0 & (~req1 | ~rr);
  assign gnt1 = req1 & (~req0 | rr);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr <= 1'b0;
    end else if (grant_accept) begin
      rr <= ~rr;
    end
  end

endmodule

// File: rtl/ysyx_23060061_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4 arbiter with a
// single outstanding transaction; responses go only to the granted master.
module ysyx_23060061_axi_arbiter
  import ysyx_23060061_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_araddr,
  input  logic [3:0]    m0_arid,
  input  logic [7:0]    m0_arlen,
  input  logic [2:0]    m0_arsize,
  input  logic [1:0]    m0_arburst,
  input  logic          m0_arvalid,
  output logic          m0_arready,
  output logic [DW-1:0] m0_rdata,
  output logic [1:0]    m0_rresp,
  output logic          m0_rlast,
  output logic [3:0]    m0_rid,
  output logic          m0_rvalid,
  input  logic          m0_rready,
  input  logic [AW-1:0] m1_araddr,
  input  logic [3:0]    m1_arid,
  input  logic [7:0]    m1_arlen,
  input  logic [2:0]    m1_arsize,
  input  logic [1:0]    m1_arburst,
  input  logic          m1_arvalid,
  output logic          m1_arready,
  output logic [DW-1:0] m1_rdata,
  output logic [1:0]    m1_rresp,
  output logic          m1_rlast,
  output logic [3:0]    m1_rid,
  output logic          m1_rvalid,
  input  logic          m1_rready,
  input  logic [AW-1:0] m1_awaddr,
  input  logic          m1_awvalid,
  output logic          m1_awready,
  input  logic [DW-1:0] m1_wdata,
  input  logic [3:0]    m1_wstrb,
  input  logic          m1_wvalid,
  output logic          m1_wready,
  output logic [1:0]    m1_bresp,
  output logic          m1_bvalid,
  input  logic          m1_bready,
  output logic [AW-1:0] s_araddr,
  output logic [3:0]    s_arid,
  output logic [7:0]    s_arlen,
  output logic [2:0]    s_arsize,
  output logic [1:0]    s_arburst,
  output logic          s_arvalid,
  input  logic          s_arready,
  input  logic [DW-1:0] s_rdata,
  input  logic [1:0]    s_rresp,
  input  logic          s_rlast,
  input  logic [3:0]    s_rid,
  input  logic          s_rvalid,
  output logic          s_rready,
  output logic [AW-1:0] s_awaddr,
  output logic          s_awvalid,
  input  logic          s_awready,
  output logic [DW-1:0] s_wdata,
  output logic [3:0]    s_wstrb,
  output logic          s_wvalid,
  input  logic          s_wready,
  input  logic [1:0]    s_bresp,
  input  logic          s_bvalid,
  output logic          s_bready
);

  arb_state_e state;
  logic       ar_done, aw_done, w_done;
  logic       gnt0, gnt1, grant_accept;

  // A read grant is committed only when no write pre-empts it.
  assign grant_accept = (state == IDLE) & ~m1_awvalid & (m0_arvalid | m1_arvalid);

  ysyx_23060061_rr_arb u_rr_arb (
    .clk          (clk),
    .rst          (rst),
    .req0         (m0_arvalid),
    .req1         (m1_arvalid),
    .grant_accept (grant_accept),
    .gnt0         (gnt0),
    .gnt1         (gnt1)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ar_done <= 1'b0;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (m1_awvalid)  state <= WR1;
          else if (gnt0)   state <= RD0;
          else if (gnt1)   state <= RD1;
        end
        RD0, RD1: begin
          if (s_arvalid && s_arready)           ar_done <= 1'b1;
          if (s_rvalid && s_rready && s_rlast)  state   <= IDLE;
        end
        WR1: begin
          if (s_awvalid && s_awready) aw_done <= 1'b1;
          if (s_wvalid && s_wready)   w_done  <= 1'b1;
          if (s_bvalid && s_bready)   state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    m0_arready = 1'b0;  m0_rdata = '0;  m0_rresp = '0;  m0_rlast = 1'b0;
    m0_rid     = '0;    m0_rvalid = 1'b0;
    m1_arready = 1'b0;  m1_rdata = '0;  m1_rresp = '0;  m1_rlast = 1'b0;
    m1_rid     = '0;    m1_rvalid = 1'b0;
    m1_awready = 1'b0;  m1_wready = 1'b0;  m1_bresp = '0;  m1_bvalid = 1'b0;
    s_araddr   = '0;    s_arid = '0;  s_arlen = '0;  s_arsize = '0;
    s_arburst  = '0;    s_arvalid = 1'b0;  s_rready = 1'b0;
    s_awaddr   = '0;    s_awvalid = 1'b0;
    s_wdata    = '0;    s_wstrb = '0;  s_wvalid = 1'b0;  s_bready = 1'b0;
    unique case (state)
      RD0: begin
        s_araddr   = m0_araddr;   s_arid   = m0_arid;    s_arlen = m0_arlen;
        s_arsize   = m0_arsize;   s_arburst = m0_arburst;
        s_arvalid  = m0_arvalid & ~ar_done;
        m0_arready = s_arready & ~ar_done;
        m0_rdata   = s_rdata;     m0_rresp = s_rresp;    m0_rlast = s_rlast;
        m0_rid     = s_rid;       m0_rvalid = s_rvalid;
        s_rready   = m0_rready;
      end
      RD1: begin
        s_araddr   = m1_araddr;   s_arid   = m1_arid;    s_arlen = m1_arlen;
        s_arsize   = m1_arsize;   s_arburst = m1_arburst;
        s_arvalid  = m1_arvalid & ~ar_done;
        m1_arready = s_arready & ~ar_done;
        m1_rdata   = s_rdata;     m1_rresp = s_rresp;    m1_rlast = s_rlast;
        m1_rid     = s_rid;       m1_rvalid = s_rvalid;
        s_rready   = m1_rready;
      end
      WR1: begin
        // AW and W complete independently; only B ends the transaction.
        s_awaddr   = m1_awaddr;
        s_awvalid  = m1_awvalid & ~aw_done;
        m1_awready = s_awready & ~aw_done;
        s_wdata    = m1_wdata;    s_wstrb  = m1_wstrb;
        s_wvalid   = m1_wvalid & ~w_done;
        m1_wready  = s_wready & ~w_done;
        m1_bresp   = s_bresp;     m1_bvalid = s_bvalid;
        s_bready   = m1_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060061_axi_arbiter.sv
// Directed self-checking bench for the two-master AXI arbiter.
module tb_ysyx_23060061_axi_arbiter;

  logic        clk, rst;
  logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata;
  logic [3:0]  m0_arid, m1_arid, m1_wstrb;
  logic [7:0]  m0_arlen, m1_arlen;
  logic [2:0]  m0_arsize, m1_arsize;
  logic [1:0]  m0_arburst, m1_arburst;
  logic        m0_arvalid, m0_rready, m1_arvalid, m1_rready;
  logic        m1_awvalid, m1_wvalid, m1_bready;
  logic        m0_arready, m0_rlast, m0_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp, m1_bresp;
  logic [3:0]  m0_rid, m1_rid;
  logic        m1_arready, m1_rlast, m1_rvalid, m1_awready, m1_wready, m1_bvalid;
  logic [31:0] s_araddr, s_awaddr, s_wdata, s_rdata;
  logic [3:0]  s_arid, s_wstrb, s_rid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp, s_bresp;
  logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;

  int checks = 0;
  int failures = 0;
  int ar_hs = 0;
  int ar_hs_base;

  ysyx_23060061_axi_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
    .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid),
    .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rlast(m0_rlast), .m0_rid(m0_rid), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
    .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid),
    .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rlast(m1_rlast), .m1_rid(m1_rid), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid),
    .m1_wready(m1_wready), .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid),
    .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (s_arvalid && s_arready) ar_hs <= ar_hs + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    m0_araddr = '0; m0_arid = '0; m0_arlen = '0; m0_arsize = 3'd2; m0_arburst = 2'd1;
    m0_arvalid = 1'b0; m0_rready = 1'b0;
    m1_araddr = '0; m1_arid = '0; m1_arlen = '0; m1_arsize = 3'd2; m1_arburst = 2'd1;
    m1_arvalid = 1'b0; m1_rready = 1'b0;
    m1_awaddr = '0; m1_awvalid = 1'b0; m1_wdata = '0; m1_wstrb = '0;
    m1_wvalid = 1'b0; m1_bready = 1'b0;
    s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rid = '0;
    s_rvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    do_reset();
    settle();
    check("reset_state", dut.state, 2'd0);
    check("reset_s_arvalid", s_arvalid, 1'b0);
    check("reset_s_awvalid", s_awvalid, 1'b0);
    check("reset_m0_arready", m0_arready, 1'b0);
    check("reset_m1_bvalid", m1_bvalid, 1'b0);

    // Single IFU read
    step();
    m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1; m0_rready = 1'b1;
    settle();
    check("t1_idle_no_arvalid", s_arvalid, 1'b0);
    step();
    check("t1_state_rd0", dut.state, 2'd1);
    check("t1_s_arvalid", s_arvalid, 1'b1);
    check("t1_s_araddr", s_araddr, 32'h8000_0000);
    check("t1_s_arsize", s_arsize, 3'd2);
    check("t1_s_arburst", s_arburst, 2'd1);
    s_arready = 1'b1;
    settle();
    check("t1_m0_arready", m0_arready, 1'b1);
    step();
    m0_arvalid = 1'b0; s_arready = 1'b0;
    step();
    step();
    s_rvalid = 1'b1; s_rdata = 32'h0000_0413; s_rresp = 2'd0; s_rlast = 1'b1; s_rid = 4'd0;
    settle();
    check("t1_m0_rvalid", m0_rvalid, 1'b1);
    check("t1_m0_rdata", m0_rdata, 32'h0000_0413);
    check("t1_m0_rresp", m0_rresp, 2'd0);
    check("t1_m0_rid", m0_rid, 4'd0);
    check("t1_m0_rlast", m0_rlast, 1'b1);
    check("t1_m1_rvalid", m1_rvalid, 1'b0);
    step();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    check("t1_back_idle", dut.state, 2'd0);

    // Simultaneous reads: m0 first, then m1 wins against a fresh m0 request
    do_reset();
    m0_araddr = 32'h8000_0010; m0_arvalid = 1'b1; m0_rready = 1'b1;
    m1_araddr = 32'h8000_0020; m1_arid = 4'd1; m1_arvalid = 1'b1; m1_rready = 1'b1;
    step();
    check("t2_first_rd0", dut.state, 2'd1);
    check("t2_first_addr", s_araddr, 32'h8000_0010);
    check("t2_m1_arready_0", m1_arready, 1'b0);
    s_arready = 1'b1;
    step();
    m0_arvalid = 1'b0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h11; s_rlast = 1'b1;
    settle();
    check("t2_m0_rdata", m0_rdata, 32'h11);
    check("t2_m1_no_rvalid", m1_rvalid, 1'b0);
    m0_araddr = 32'h8000_0030; m0_arvalid = 1'b1;
    step();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    check("t2_idle_after_last", dut.state, 2'd0);
    step();
    check("t2_m1_granted", dut.state, 2'd2);
    check("t2_m1_addr", s_araddr, 32'h8000_0020);
    check("t2_m1_arid", s_arid, 4'd1);
    check("t2_m0_arready_0", m0_arready, 1'b0);
    s_arready = 1'b1;
    step();
    m1_arvalid = 1'b0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h22; s_rid = 4'd1; s_rlast = 1'b1;
    settle();
    check("t2_m1_rdata", m1_rdata, 32'h22);
    check("t2_m1_rid", m1_rid, 4'd1);
    check("t2_m0_no_rvalid", m0_rvalid, 1'b0);
    step();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    step();
    check("t2_m0_second", dut.state, 2'd1);
    check("t2_m0_second_addr", s_araddr, 32'h8000_0030);

    // Write concurrent with IFU read: write first, W ahead of AW
    do_reset();
    m1_awaddr = 32'h8000_0100; m1_awvalid = 1'b1;
    m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF; m1_wvalid = 1'b1; m1_bready = 1'b1;
    m0_araddr = 32'h8000_0200; m0_arvalid = 1'b1; m0_rready = 1'b1;
    step();
    check("t3_state_wr1", dut.state, 2'd3);
    check("t3_s_awvalid", s_awvalid, 1'b1);
    check("t3_s_awaddr", s_awaddr, 32'h8000_0100);
    check("t3_s_wdata", s_wdata, 32'hDEAD_BEEF);
    check("t3_s_wstrb", s_wstrb, 4'hF);
    check("t3_s_arvalid_0", s_arvalid, 1'b0);
    s_wready = 1'b1;
    settle();
    check("t3_m1_wready", m1_wready, 1'b1);
    check("t3_m1_awready_0", m1_awready, 1'b0);
    check("t3_m0_arready_0a", m0_arready, 1'b0);
    step();
    s_wready = 1'b0;
    check("t3_s_wvalid_gated", s_wvalid, 1'b0);
    check("t3_s_awvalid_held", s_awvalid, 1'b1);
    s_awready = 1'b1;
    settle();
    check("t3_m1_awready", m1_awready, 1'b1);
    step();
    s_awready = 1'b0;
    check("t3_s_awvalid_gated", s_awvalid, 1'b0);
    check("t3_still_wr1", dut.state, 2'd3);
    m1_awvalid = 1'b0; m1_wvalid = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'd0;
    settle();
    check("t3_m1_bvalid", m1_bvalid, 1'b1);
    check("t3_m1_bresp", m1_bresp, 2'd0);
    check("t3_s_bready", s_bready, 1'b1);
    check("t3_m0_arready_0b", m0_arready, 1'b0);
    step();
    s_bvalid = 1'b0;
    check("t3_idle", dut.state, 2'd0);
    check("t3_m1_bvalid_0", m1_bvalid, 1'b0);
    step();
    check("t3_m0_follows", dut.state, 2'd1);
    check("t3_m0_addr", s_araddr, 32'h8000_0200);

    // Slow arready, then R with m0_rready toggling
    do_reset();
    m0_araddr = 32'h8000_0300; m0_arvalid = 1'b1; m0_rready = 1'b0;
    step();
    ar_hs_base = ar_hs;
    for (int i = 0; i < 5; i++) begin
      check("t4_wait_arvalid", s_arvalid, 1'b1);
      check("t4_wait_arready", m0_arready, 1'b0);
      step();
    end
    s_arready = 1'b1;
    step();
    settle();
    check("t4_arvalid_gated", s_arvalid, 1'b0);
    check("t4_arready_gated", m0_arready, 1'b0);
    m0_arvalid = 1'b0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h55; s_rlast = 1'b1;
    settle();
    check("t4_rready_low", s_rready, 1'b0);
    step();
    check("t4_no_end_without_rready", dut.state, 2'd1);
    m0_rready = 1'b1;
    settle();
    check("t4_rready_high", s_rready, 1'b1);
    check("t4_m0_rdata", m0_rdata, 32'h55);
    step();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    check("t4_idle", dut.state, 2'd0);
    check("t4_one_ar_handshake", ar_hs - ar_hs_base, 1);

    // 4-beat burst for m1 with SLVERR on the second beat
    do_reset();
    m1_araddr = 32'h8000_0400; m1_arlen = 8'd3; m1_arid = 4'd2;
    m1_arvalid = 1'b1; m1_rready = 1'b1;
    step();
    check("t5_state_rd1", dut.state, 2'd2);
    check("t5_s_arlen", s_arlen, 8'd3);
    check("t5_s_arid", s_arid, 4'd2);
    s_arready = 1'b1;
    step();
    m1_arvalid = 1'b0; s_arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_rvalid = 1'b1; s_rdata = 32'h1000 + 32'(i); s_rid = 4'd2;
      s_rresp = (i == 1) ? 2'd2 : 2'd0;
      s_rlast = (i == 3);
      settle();
      check("t5_beat_rdata", m1_rdata, 32'h1000 + 32'(i));
      check("t5_beat_rresp", m1_rresp, (i == 1) ? 2'd2 : 2'd0);
      check("t5_beat_rlast", m1_rlast, (i == 3));
      check("t5_beat_m0_rvalid", m0_rvalid, 1'b0);
      step();
      check("t5_state_after_beat", dut.state, (i == 3) ? 2'd0 : 2'd2);
    end
    s_rvalid = 1'b0; s_rlast = 1'b0; s_rresp = 2'd0;

    // Reset mid-RD1, then a fresh m0 read
    do_reset();
    m1_araddr = 32'h8000_0500; m1_arvalid = 1'b1; m1_rready = 1'b1;
    step();
    check("t6_state_rd1", dut.state, 2'd2);
    s_arready = 1'b1;
    step();
    m1_arvalid = 1'b0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h77; s_rlast = 1'b0;
    settle();
    check("t6_m1_rvalid_before", m1_rvalid, 1'b1);
    rst = 1'b0;
    step();
    check("t6_reset_idle", dut.state, 2'd0);
    check("t6_reset_s_arvalid", s_arvalid, 1'b0);
    check("t6_reset_s_rready", s_rready, 1'b0);
    check("t6_reset_m1_rvalid", m1_rvalid, 1'b0);
    check("t6_reset_m1_arready", m1_arready, 1'b0);
    check("t6_reset_s_awvalid", s_awvalid, 1'b0);
    rst = 1'b1;
    s_rvalid = 1'b0;
    step();
    m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1; m0_rready = 1'b1;
    step();
    check("t6_fresh_rd0", dut.state, 2'd1);
    s_arready = 1'b1;
    step();
    m0_arvalid = 1'b0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h99; s_rlast = 1'b1;
    settle();
    check("t6_fresh_rdata", m0_rdata, 32'h99);
    step();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    check("t6_fresh_idle", dut.state, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060061_axi_arbiter.md
# ysyx_23060061_axi_arbiter

Two-master to one-slave AXI4 arbiter sitting directly downstream of the instruction-fetch unit's AXI master port. It merges the IFU read traffic (master 0, read-only) with the load/store unit's traffic (master 1, read and write) onto the single memory/SRAM slave port. One transaction is outstanding at a time. Responses are routed back only to the granted master.

## Interface
- Parameters:
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `m0_araddr/arid/arlen/arsize/arburst/arvalid` in AW/4/8/3/2/1: IFU read address channel.
- `m0_arready` out 1: IFU AR accept.
- `m0_rdata/rresp/rlast/rid/rvalid` out DW/2/1/4/1: IFU read data channel.
- `m0_rready` in 1: IFU read data accept.
- `m1_ar*`, `m1_r*`: same set and widths as m0, for the LSU.
- `m1_awaddr/awvalid` in AW/1: LSU write address.
- `m1_awready` out 1: LSU write address accept.
- `m1_wdata/wstrb/wvalid` in DW/4/1: LSU write data.
- `m1_wready` out 1: LSU write data accept.
- `m1_bresp/bvalid` out 2/1: LSU write response.
- `m1_bready` in 1: LSU write response accept.
- `s_*`: mirror of the union of the above toward the slave, with directions inverted.

## Operation
- States: IDLE, RD0 (read granted to m0), RD1 (read granted to m1), WR1 (write granted to m1).
- In IDLE, on a registered decision:
  - `m1_awvalid` → WR1. Writes have highest priority.
  - Otherwise, if both `m0_arvalid` and `m1_arvalid` are high, the round-robin pointer `rr` picks the master. `rr`=0 favours m0. `rr` flips after every read grant.
  - Otherwise, the single requester is granted.
- RDx: AR signals of master x pass combinationally to `s_ar*`. An internal `ar_done` flag is set on the `s_arvalid&s_arready` handshake. After that, `s_arvalid` is forced to 0. The R channel routes to master x, and `s_rready` equals `mx_rready`. The transaction ends on `s_rvalid&s_rready&s_rlast`, returning to IDLE next cycle.
- WR1: AW and W pass through independently. `aw_done` and `w_done` flags each gate their valid after the handshake. B routes to m1. The transaction ends on `s_bvalid&s_bready`, returning to IDLE.
- Non-granted master: ready outputs 0, valid outputs 0, data outputs 0.
- `rresp`/`bresp`/`rid` pass through unmodified, including SLVERR/DECERR.
- Reset values: state=IDLE, `rr`=0, all flags 0, every valid/ready output 0.

## Timing
- Request seen in IDLE at cycle N → grant state at N+1 → `s_arvalid`/`s_awvalid` high at N+1 (combinational from state). Arbitration cost is one cycle.
- Handshake completing on the last beat at cycle M → IDLE at M+1 → earliest next grant at M+2.
- A master dropping `arvalid` before grant in IDLE: no grant. Dropping after grant violates AXI; this case is not handled.
- A request arriving during a busy state waits with ready=0 and must hold its valid.
- Burst reads (`arlen`>0): all beats go to the same master; only `rlast` terminates.
- W accepted before AW, or in the same cycle: both are legal, and completion waits for B only.
- Reset mid-transaction: immediate return to IDLE and all outputs 0. The slave shares `rst` and must also abort.

## Structure
- Shared package `ysyx_23060061_pkg`:
  - state encoding (IDLE=0, RD0=1, RD1=2, WR1=3);
  - AXI resp constants (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3);
  - burst constant INCR=1.
- One sub-module, `ysyx_23060061_rr_arb`: two-request round-robin grant with pointer update on `grant_accept`. The muxing and FSM stay in the top.

## Test plan
- Single IFU read, `araddr`=0x8000_0000, slave returns 0x0000_0413, OKAY, after 3 cycles → m0 receives `rdata`=0x0000_0413 with `rlast`=1; m1 sees no `rvalid`; state back in IDLE one cycle later.
- m0 and m1 assert `arvalid` in the same cycle, both held → m0 granted first; m1 is granted in the cycle after m0's final R handshake +1; then, with both requesting again, m1 wins.
- m1 write (`awaddr`=0x8000_0100, `wdata`=0xDEADBEEF, `wstrb`=0xF) concurrent with m0 read → write granted first; `bresp`=OKAY reaches m1; m0 read follows; `m0_arready` stays 0 throughout WR1.
- Slave holds `arready`=0 for 5 cycles, then `rvalid` with `m0_rready` toggling → exactly one AR handshake, and `s_arvalid`=0 after it. Data is delivered only on cycles with `m0_rready`=1.
- 4-beat burst (`arlen`=3) for m1 with slave SLVERR on beat 2 → all 4 beats reach m1 with per-beat `rresp`; the transaction ends only on `rlast`.
- `rst` driven low mid-RD1 → next cycle state=IDLE and all valid/ready outputs 0; after `rst` goes high, a fresh m0 read completes normally.
